// File: rtl/nec_prefetch_ctrl_pkg.sv
// Shared types for the V30-style prefetch controller: FSM states and bus byte-lane encodings.
package nec_prefetch_ctrl_pkg;

  localparam int IPQ_DEPTH = 8;

  typedef enum logic [2:0] {
    HALTED  = 3'd0,
    IDLE    = 3'd1,
    FETCH   = 3'd2,
    DATA_LO = 3'd3,
    DATA_HI = 3'd4
  } prefetch_state_e;

  typedef enum logic [1:0] {
    BE_NONE = 2'b00,
    BE_EVEN = 2'b01,
    BE_ODD  = 2'b10,
    BE_WORD = 2'b11
  } bus_lane_e;

  // Lanes for the first (or only) bus cycle of a data access.
  function automatic bus_lane_e data_lanes(input logic addr0, input logic word);
    if (addr0) return BE_ODD;
    return word ? BE_WORD : BE_EVEN;
  endfunction

endpackage

// File: rtl/nec_ipq_store.sv
// 8-byte instruction prefetch queue storage; one write port per bus lane.
module nec_ipq_store
  import nec_prefetch_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        even_we_i,
  input  logic [2:0]  even_idx_i,
  input  logic [7:0]  even_data_i,
  input  logic        odd_we_i,
  input  logic [2:0]  odd_idx_i,
  input  logic [7:0]  odd_data_i,
  output logic [63:0] ipq_o
);

  logic [7:0] mem_q [IPQ_DEPTH];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < IPQ_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      if (even_we_i) mem_q[even_idx_i] <= even_data_i;
      if (odd_we_i)  mem_q[odd_idx_i]  <= odd_data_i;
    end
  end

  for (genvar g = 0; g < IPQ_DEPTH; g++) begin : g_flat
    assign ipq_o[8*g +: 8] = mem_q[g];
  end

endmodule

// File: rtl/nec_prefetch_ctrl.sv
// Prefetch queue owner and 16-bit bus arbiter: data accesses win over code fetch,
// odd-address word accesses are split into two byte cycles.
module nec_prefetch_ctrl
  import nec_prefetch_ctrl_pkg::*;
#(
  parameter int QUEUE_BYTES = IPQ_DEPTH
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ce_1_i,
  input  logic        ce_2_i,
  input  logic [15:0] ps_i,
  input  logic        set_pc_i,
  input  logic [15:0] new_pc_i,
  input  logic [15:0] decode_pc_i,
  output logic [63:0] ipq_o,
  output logic [3:0]  ipq_len_o,
  input  logic        dreq_i,
  input  logic [19:0] dreq_addr_i,
  input  logic        dreq_write_i,
  input  logic        dreq_word_i,
  input  logic [15:0] dreq_wdata_i,
  output logic        dack_o,
  output logic [15:0] drdata_o,
  output logic        bus_req_o,
  output logic [19:0] bus_addr_o,
  output logic        bus_write_o,
  output logic [1:0]  bus_be_o,
  output logic [15:0] bus_wdata_o,
  output logic        bus_fetch_o,
  input  logic        bus_ack_i,
  input  logic [15:0] bus_rdata_i
);

  prefetch_state_e state_q;
  logic [15:0] fetch_ptr_q;
  logic        discard_q;
  logic        fetch_word_q;
  logic [7:0]  lo_byte_q;
  logic        bus_req_q;
  logic [19:0] bus_addr_q;
  logic        bus_write_q;
  logic [1:0]  bus_be_q;
  logic [15:0] bus_wdata_q;
  logic        bus_fetch_q;
  logic        dack_q;
  logic [15:0] drdata_q;

  logic        ce;
  logic [15:0] q_len;
  logic [4:0]  free_bytes;
  logic [19:0] fetch_addr;
  logic [19:0] data_lo_addr;
  logic [19:0] data_hi_addr;
  logic        odd_word;
  logic [15:0] read_steer;
  logic [15:0] lo_wdata;
  logic        fetch_done;
  logic        unused_len;

  assign ce         = ce_1_i | ce_2_i;
  assign q_len      = fetch_ptr_q - decode_pc_i;
  assign unused_len = ^q_len[15:4];
  assign free_bytes = 5'(QUEUE_BYTES) - {1'b0, q_len[3:0]};
  assign ipq_len_o  = (state_q == HALTED) ? 4'd0 : q_len[3:0];

  assign fetch_addr   = ({ps_i, 4'h0} + {4'h0, fetch_ptr_q}) & 20'hFFFFE;
  assign data_lo_addr = dreq_addr_i & 20'hFFFFE;
  assign data_hi_addr = dreq_addr_i + 20'd1;
  assign odd_word     = dreq_word_i & dreq_addr_i[0];

  always_comb begin
    read_steer = bus_rdata_i;
    lo_wdata   = dreq_wdata_i;
    if (!dreq_word_i) begin
      read_steer = {8'h00, dreq_addr_i[0] ? bus_rdata_i[15:8] : bus_rdata_i[7:0]};
      lo_wdata   = {2{dreq_wdata_i[7:0]}};
    end else if (dreq_addr_i[0]) begin
      lo_wdata   = {dreq_wdata_i[7:0], 8'h00};
    end
  end

  // A branch landing on the ack edge, or an earlier one, makes the returning code stale.
  assign fetch_done = ce && !reset_i && (state_q == FETCH) && bus_ack_i
                      && !discard_q && !set_pc_i;

  nec_ipq_store u_store (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .even_we_i   (fetch_done & fetch_word_q),
    .even_idx_i  (fetch_ptr_q[2:0]),
    .even_data_i (bus_rdata_i[7:0]),
    .odd_we_i    (fetch_done),
    .odd_idx_i   (fetch_word_q ? fetch_ptr_q[2:0] + 3'd1 : fetch_ptr_q[2:0]),
    .odd_data_i  (bus_rdata_i[15:8]),
    .ipq_o       (ipq_o)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= HALTED;
      fetch_ptr_q  <= 16'h0000;
      discard_q    <= 1'b0;
      fetch_word_q <= 1'b0;
      lo_byte_q    <= 8'h00;
      bus_req_q    <= 1'b0;
      bus_addr_q   <= 20'h00000;
      bus_write_q  <= 1'b0;
      bus_be_q     <= BE_NONE;
      bus_wdata_q  <= 16'h0000;
      bus_fetch_q  <= 1'b0;
      dack_q       <= 1'b0;
      drdata_q     <= 16'h0000;
    end else if (ce) begin
      dack_q <= 1'b0;
      if (set_pc_i) fetch_ptr_q <= new_pc_i;
      unique case (state_q)
        HALTED: if (set_pc_i) state_q <= IDLE;
        IDLE: begin
          // dack_q guards against re-issuing for a request the EU has not yet dropped.
          if (!set_pc_i) begin
            if (dreq_i && !dack_q) begin
              state_q     <= DATA_LO;
              bus_req_q   <= 1'b1;
              bus_fetch_q <= 1'b0;
              bus_write_q <= dreq_write_i;
              bus_addr_q  <= data_lo_addr;
              bus_be_q    <= data_lanes(dreq_addr_i[0], dreq_word_i);
              bus_wdata_q <= lo_wdata;
            end else if (fetch_ptr_q[0] && free_bytes >= 5'd1) begin
              state_q      <= FETCH;
              bus_req_q    <= 1'b1;
              bus_fetch_q  <= 1'b1;
              bus_write_q  <= 1'b0;
              bus_addr_q   <= fetch_addr;
              bus_be_q     <= BE_ODD;
              fetch_word_q <= 1'b0;
            end else if (!fetch_ptr_q[0] && free_bytes >= 5'd2) begin
              state_q      <= FETCH;
              bus_req_q    <= 1'b1;
              bus_fetch_q  <= 1'b1;
              bus_write_q  <= 1'b0;
              bus_addr_q   <= fetch_addr;
              bus_be_q     <= BE_WORD;
              fetch_word_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (bus_ack_i) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_fetch_q <= 1'b0;
            bus_be_q    <= BE_NONE;
            discard_q   <= 1'b0;
            if (!set_pc_i && !discard_q)
              fetch_ptr_q <= fetch_ptr_q + (fetch_word_q ? 16'd2 : 16'd1);
          end else if (set_pc_i) begin
            discard_q <= 1'b1;
          end
        end
        DATA_LO: begin
          if (bus_ack_i) begin
            if (odd_word) begin
              state_q     <= DATA_HI;
              lo_byte_q   <= bus_rdata_i[15:8];
              bus_addr_q  <= data_hi_addr;
              bus_be_q    <= BE_EVEN;
              bus_wdata_q <= {8'h00, dreq_wdata_i[15:8]};
            end else begin
              state_q     <= IDLE;
              bus_req_q   <= 1'b0;
              bus_write_q <= 1'b0;
              bus_be_q    <= BE_NONE;
              dack_q      <= 1'b1;
              if (!dreq_write_i) drdata_q <= read_steer;
            end
          end
        end
        DATA_HI: begin
          if (bus_ack_i) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_write_q <= 1'b0;
            bus_be_q    <= BE_NONE;
            dack_q      <= 1'b1;
            if (!dreq_write_i) drdata_q <= {bus_rdata_i[7:0], lo_byte_q};
          end
        end
        default: state_q <= HALTED;
      endcase
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_write_o = bus_write_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_fetch_o = bus_fetch_q;
  assign dack_o      = dack_q;
  assign drdata_o    = drdata_q;

endmodule

// File: tb/tb_nec_prefetch_ctrl.sv
// Directed bench for nec_prefetch_ctrl with a simple acking bus model.
module tb_nec_prefetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_1 = 1'b1, ce_2 = 1'b0;
  logic [15:0] ps = '0, new_pc = '0, decode_pc = '0;
  logic        set_pc = 1'b0;
  logic [63:0] ipq;
  logic [3:0]  ipq_len;
  logic        dreq = 1'b0, dreq_write = 1'b0, dreq_word = 1'b0;
  logic [19:0] dreq_addr = '0;
  logic [15:0] dreq_wdata = '0;
  logic        dack;
  logic [15:0] drdata;
  logic        bus_req, bus_write, bus_fetch;
  logic [19:0] bus_addr;
  logic [1:0]  bus_be;
  logic [15:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_rdata = '0;

  int checks = 0;
  int failures = 0;
  int ack_delay = 0;
  int wait_cnt = 0;

  logic [19:0] log_addr[$];
  logic [1:0]  log_be[$];
  logic        log_fetch[$];
  logic        log_write[$];
  logic [15:0] log_wdata[$];
  logic [15:0] ovr_q[$];

  always #5 clk = ~clk;

  nec_prefetch_ctrl dut (
    .clk_i(clk), .reset_i(reset), .ce_1_i(ce_1), .ce_2_i(ce_2),
    .ps_i(ps), .set_pc_i(set_pc), .new_pc_i(new_pc), .decode_pc_i(decode_pc),
    .ipq_o(ipq), .ipq_len_o(ipq_len),
    .dreq_i(dreq), .dreq_addr_i(dreq_addr), .dreq_write_i(dreq_write),
    .dreq_word_i(dreq_word), .dreq_wdata_i(dreq_wdata),
    .dack_o(dack), .drdata_o(drdata),
    .bus_req_o(bus_req), .bus_addr_o(bus_addr), .bus_write_o(bus_write),
    .bus_be_o(bus_be), .bus_wdata_o(bus_wdata), .bus_fetch_o(bus_fetch),
    .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata)
  );

  function automatic logic [7:0] mem_byte(input logic [19:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [15:0] mem_word(input logic [19:0] a);
    return {mem_byte({a[19:1], 1'b1}), mem_byte({a[19:1], 1'b0})};
  endfunction

  // Bus model: acks ack_delay cycles after it first sees a request, one-cycle pulse.
  always @(negedge clk) begin
    if (reset) begin
      bus_ack  = 1'b0;
      wait_cnt = 0;
    end else if (bus_ack) begin
      bus_ack = 1'b0;
    end else if (bus_req) begin
      if (wait_cnt >= ack_delay) begin
        wait_cnt = 0;
        bus_ack  = 1'b1;
        if (!bus_fetch && ovr_q.size() > 0) bus_rdata = ovr_q.pop_front();
        else bus_rdata = mem_word(bus_addr);
        log_addr.push_back(bus_addr);
        log_be.push_back(bus_be);
        log_fetch.push_back(bus_fetch);
        log_write.push_back(bus_write);
        log_wdata.push_back(bus_wdata);
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; set_pc = 1'b0; dreq = 1'b0; ack_delay = 0;
    tick(); tick();
    reset = 1'b0;
    log_addr.delete(); log_be.delete(); log_fetch.delete();
    log_write.delete(); log_wdata.delete(); ovr_q.delete();
  endtask

  task automatic start_at(input logic [15:0] seg, input logic [15:0] pc, input logic [15:0] dpc);
    ps = seg; new_pc = pc; decode_pc = dpc; set_pc = 1'b1;
    tick();
    set_pc = 1'b0;
  endtask

  task automatic test_reset();
    decode_pc = 16'h1234;
    do_reset();
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL reset_bus_req got=%0b exp=0", bus_req); end
    checks++; if (bus_be !== 2'b00 || bus_write !== 1'b0 || bus_fetch !== 1'b0) begin failures++; $display("FAIL reset_bus_ctl be=%b wr=%b fe=%b exp=00/0/0", bus_be, bus_write, bus_fetch); end
    checks++; if (dack !== 1'b0 || drdata !== 16'h0000) begin failures++; $display("FAIL reset_dack dack=%b drdata=%h exp=0/0000", dack, drdata); end
    checks++; if (ipq !== 64'h0) begin failures++; $display("FAIL reset_ipq got=%h exp=0", ipq); end
    tick(); tick(); tick();
    checks++; if (ipq_len !== 4'd0 || bus_req !== 1'b0) begin failures++; $display("FAIL halted_idle len=%0d req=%b exp=0/0", ipq_len, bus_req); end
  endtask

  task automatic test_fill();
    logic [3:0] seq[$];
    logic [3:0] last;
    do_reset();
    start_at(16'hFFFF, 16'h0000, 16'h0000);
    last = ipq_len;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ipq_len != last) begin seq.push_back(ipq_len); last = ipq_len; end
    end
    checks++; if (log_addr.size() != 4) begin failures++; $display("FAIL fill_count got=%0d exp=4", log_addr.size()); end
    for (int i = 0; i < 4; i++) if (i < log_addr.size()) begin
      checks++;
      if (log_addr[i] !== 20'hFFFF0 + 20'(2*i) || log_be[i] !== 2'b11 || log_fetch[i] !== 1'b1) begin
        failures++; $display("FAIL fill_cycle%0d addr=%h be=%b fe=%b exp=%h/11/1", i, log_addr[i], log_be[i], log_fetch[i], 20'hFFFF0 + 20'(2*i));
      end
    end
    checks++; if (seq.size() != 4) begin failures++; $display("FAIL fill_len_steps got=%0d steps exp=4", seq.size()); end
    for (int i = 0; i < 4; i++) if (i < seq.size()) begin
      checks++; if (seq[i] !== 4'(2*(i+1))) begin failures++; $display("FAIL fill_len%0d got=%0d exp=%0d", i, seq[i], 2*(i+1)); end
    end
    checks++; if (ipq !== 64'h5253_5051_5657_5455) begin failures++; $display("FAIL fill_ipq got=%h exp=5253505156575455", ipq); end
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL fill_full_req got=%b exp=0", bus_req); end
  endtask

  task automatic test_odd_start();
    do_reset();
    start_at(16'h0000, 16'h0003, 16'h0003);
    tick(); tick();
    checks++; if (ipq_len !== 4'd1) begin failures++; $display("FAIL odd_len got=%0d exp=1", ipq_len); end
    checks++; if (ipq[31:24] !== 8'hA6) begin failures++; $display("FAIL odd_ipq3 got=%h exp=a6", ipq[31:24]); end
    checks++; if (log_addr.size() < 1 || log_addr[0] !== 20'h00002 || log_be[0] !== 2'b10) begin failures++; $display("FAIL odd_first_cycle n=%0d exp addr=00002 be=10", log_addr.size()); end
    for (int i = 0; i < 10 && log_addr.size() < 2; i++) tick();
    checks++; if (log_addr.size() < 2 || log_addr[1] !== 20'h00004 || log_be[1] !== 2'b11) begin failures++; $display("FAIL odd_second_cycle n=%0d exp addr=00004 be=11", log_addr.size()); end
  endtask

  task automatic test_flush_discard();
    do_reset();
    ack_delay = 3;
    start_at(16'h0000, 16'h0020, 16'h0020);
    tick();
    checks++; if (bus_req !== 1'b1 || bus_addr !== 20'h00020) begin failures++; $display("FAIL flush_issue req=%b addr=%h exp=1/00020", bus_req, bus_addr); end
    new_pc = 16'h0100; decode_pc = 16'h0100; set_pc = 1'b1;
    tick();
    set_pc = 1'b0;
    tick();
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL flush_hold1 req=%b exp=1", bus_req); end
    tick();
    checks++; if (bus_req !== 1'b1 || bus_addr !== 20'h00020) begin failures++; $display("FAIL flush_hold2 req=%b addr=%h exp=1/00020", bus_req, bus_addr); end
    tick();
    checks++; if (bus_req !== 1'b0 || ipq_len !== 4'd0) begin failures++; $display("FAIL flush_done req=%b len=%0d exp=0/0", bus_req, ipq_len); end
    checks++; if (ipq !== 64'h0) begin failures++; $display("FAIL flush_discard ipq=%h exp=0", ipq); end
    tick();
    checks++; if (bus_req !== 1'b1 || bus_addr !== 20'h00100 || bus_fetch !== 1'b1) begin failures++; $display("FAIL flush_refetch req=%b addr=%h fe=%b exp=1/00100/1", bus_req, bus_addr, bus_fetch); end
    ack_delay = 0;
  endtask

  task automatic test_dreq_priority();
    int dack_cnt;
    logic [15:0] rd;
    dack_cnt = 0; rd = '0;
    do_reset();
    ack_delay = 1;
    start_at(16'h1000, 16'h0000, 16'h0000);
    tick();
    checks++; if (bus_fetch !== 1'b1 || bus_addr !== 20'h10000) begin failures++; $display("FAIL prio_fetch fe=%b addr=%h exp=1/10000", bus_fetch, bus_addr); end
    dreq_addr = 20'h00201; dreq_word = 1'b0; dreq_write = 1'b0; dreq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dack) begin dack_cnt++; rd = drdata; dreq = 1'b0; end
    end
    checks++; if (dack_cnt != 1) begin failures++; $display("FAIL prio_dack_count got=%0d exp=1", dack_cnt); end
    checks++; if (rd !== 16'h00A4) begin failures++; $display("FAIL prio_byte_read got=%h exp=00a4", rd); end
    checks++; if (log_addr.size() < 3 || log_fetch[0] !== 1'b1 || log_fetch[1] !== 1'b0 || log_addr[1] !== 20'h00200 || log_be[1] !== 2'b10) begin failures++; $display("FAIL prio_order n=%0d exp fetch,data@00200 be=10", log_addr.size()); end
    checks++; if (log_addr.size() < 3 || log_fetch[2] !== 1'b1 || log_addr[2] !== 20'h10002) begin failures++; $display("FAIL prio_resume n=%0d exp fetch@10002", log_addr.size()); end
    ack_delay = 0;
  endtask

  task automatic test_odd_word_read();
    logic seen;
    logic [15:0] rd;
    seen = 1'b0; rd = '0;
    do_reset();
    ovr_q.push_back(16'hAB00); ovr_q.push_back(16'h00CD);
    dreq_addr = 20'h12345; dreq_word = 1'b1; dreq_write = 1'b0; dreq = 1'b1;
    start_at(16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dack) begin seen = 1'b1; rd = drdata; dreq = 1'b0; break; end
    end
    checks++; if (!seen || rd !== 16'hCDAB) begin failures++; $display("FAIL oddrd_data seen=%b got=%h exp=cdab", seen, rd); end
    checks++; if (log_addr.size() < 2 || log_addr[0] !== 20'h12344 || log_be[0] !== 2'b10 || log_fetch[0] !== 1'b0) begin failures++; $display("FAIL oddrd_lo n=%0d exp addr=12344 be=10", log_addr.size()); end
    checks++; if (log_addr.size() < 2 || log_addr[1] !== 20'h12346 || log_be[1] !== 2'b01 || log_fetch[1] !== 1'b0) begin failures++; $display("FAIL oddrd_hi n=%0d exp addr=12346 be=01", log_addr.size()); end
  endtask

  task automatic test_odd_word_write_wrap();
    logic seen;
    seen = 1'b0;
    do_reset();
    dreq_addr = 20'hFFFFF; dreq_word = 1'b1; dreq_write = 1'b1; dreq_wdata = 16'hBEEF; dreq = 1'b1;
    start_at(16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dack) begin seen = 1'b1; dreq = 1'b0; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL oddwr_dack got=0 exp=1"); end
    checks++; if (log_addr.size() < 2 || log_addr[0] !== 20'hFFFFE || log_be[0] !== 2'b10 || log_write[0] !== 1'b1 || log_wdata[0][15:8] !== 8'hEF) begin failures++; $display("FAIL oddwr_lo n=%0d exp addr=ffffe be=10 wdata[15:8]=ef", log_addr.size()); end
    checks++; if (log_addr.size() < 2 || log_addr[1] !== 20'h00000 || log_be[1] !== 2'b01 || log_write[1] !== 1'b1 || log_wdata[1][7:0] !== 8'hBE) begin failures++; $display("FAIL oddwr_hi_wrap n=%0d exp addr=00000 be=01 wdata[7:0]=be", log_addr.size()); end
  endtask

  task automatic test_queue_full();
    do_reset();
    start_at(16'h0000, 16'h0009, 16'h0001);
    checks++; if (ipq_len !== 4'd8) begin failures++; $display("FAIL full_len got=%0d exp=8", ipq_len); end
    tick(); tick(); tick(); tick();
    checks++; if (log_addr.size() != 0 || bus_req !== 1'b0) begin failures++; $display("FAIL full_stall n=%0d req=%b exp=0/0", log_addr.size(), bus_req); end
    decode_pc = 16'h0002;
    for (int i = 0; i < 10 && log_addr.size() < 1; i++) tick();
    tick();
    checks++; if (log_addr.size() < 1 || log_addr[0] !== 20'h00008 || log_be[0] !== 2'b10) begin failures++; $display("FAIL full_odd_byte n=%0d exp addr=00008 be=10", log_addr.size()); end
    checks++; if (ipq_len !== 4'd8 || ipq[15:8] !== 8'hAC) begin failures++; $display("FAIL full_odd_land len=%0d ipq1=%h exp=8/ac", ipq_len, ipq[15:8]); end
    decode_pc = 16'h0003;
    tick(); tick(); tick(); tick();
    checks++; if (log_addr.size() != 1 || bus_req !== 1'b0) begin failures++; $display("FAIL full_even_stall n=%0d req=%b exp=1/0", log_addr.size(), bus_req); end
    decode_pc = 16'h0004;
    for (int i = 0; i < 10 && log_addr.size() < 2; i++) tick();
    checks++; if (log_addr.size() < 2 || log_addr[1] !== 20'h0000A || log_be[1] !== 2'b11) begin failures++; $display("FAIL full_even_word n=%0d exp addr=0000a be=11", log_addr.size()); end
  endtask

  task automatic test_ce_gating();
    do_reset();
    ce_1 = 1'b0; ce_2 = 1'b0;
    ps = 16'h0000; new_pc = 16'h0010; decode_pc = 16'h000C; set_pc = 1'b1;
    tick(); tick(); tick();
    checks++; if (ipq_len !== 4'd0 || bus_req !== 1'b0) begin failures++; $display("FAIL ce_frozen len=%0d req=%b exp=0/0", ipq_len, bus_req); end
    ce_2 = 1'b1;
    tick();
    set_pc = 1'b0;
    checks++; if (ipq_len !== 4'd4) begin failures++; $display("FAIL ce2_setpc len=%0d exp=4", ipq_len); end
    tick();
    checks++; if (bus_req !== 1'b1 || bus_addr !== 20'h00010) begin failures++; $display("FAIL ce2_fetch req=%b addr=%h exp=1/00010", bus_req, bus_addr); end
    ce_1 = 1'b1; ce_2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_odd_start();
    test_flush_discard();
    test_dreq_priority();
    test_odd_word_read();
    test_odd_word_write_wrap();
    test_queue_full();
    test_ce_gating();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
